div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the EX stage. It is the inverse-operation partner of the multiplier and uses the same start/stop/ready handshake.
- Produces quotient (LO) and remainder (HI) for DIV/DIVU.
- The pipeline controller stalls EX while the divider is busy and writes HI/LO on the ready pulse.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_step.sv | 27 ++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_unit_pkg;

  // Divider controller states; the encodings are fixed because other EX-stage logic decodes them.
  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_FINI = 2'b10,
    DIV_ZERO = 2'b11
  } div_state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // Keep the difference only when the shifted partial remainder covers the divisor.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_next    = WIDTH'(shifted - {1'b0, divisor});
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider for the EX stage; result = {remainder, quotient}.
// Optional build macro DIV_EARLY_TERM_EN: finish early when |a| < |b| (quotient 0, remainder a).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               stop,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       state_q;
  div_state_e       state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CntW-1:0]  cnt_q;
  logic             qsign_q;
  logic             rsign_q;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] rem_step_c;
  logic [WIDTH-1:0] quo_step_c;
  logic             accept_c;
  logic             b_zero_c;
  logic             early_c;

  // Operand magnitudes: negate only signed operands whose sign bit is set.
  assign a_mag_c  = (signed_div && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag_c  = (signed_div && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign accept_c = (state_q == DIV_FREE) && start && !stop;
  assign b_zero_c = (b == '0);

  // Short-circuit when the dividend magnitude is already smaller than the divisor.
`ifdef DIV_EARLY_TERM_EN
  assign early_c = !b_zero_c && (a_mag_c < b_mag_c);
`else
  assign early_c = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_step_c),
    .quo_next (quo_step_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  // Next-state logic; ZERO is a one-cycle detour so trivial cases still take two cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: if (accept_c) state_d = (b_zero_c || early_c) ? DIV_ZERO : DIV_BUSY;
      DIV_BUSY: begin
        if (stop)                            state_d = DIV_FREE;
        else if (cnt_q == CntW'(WIDTH - 1))  state_d = DIV_FINI;
      end
      DIV_ZERO: state_d = DIV_FINI;
      DIV_FINI: if (ready) state_d = DIV_FREE;
      default:  state_d = DIV_FREE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and the registered ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          ready <= 1'b0;
          if (accept_c) begin
            result  <= '0;
            dvsr_q  <= b_mag_c;
            qsign_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_q <= signed_div & a[WIDTH-1];
            cnt_q   <= '0;
            if (b_zero_c) begin
              rem_q <= '0;
              quo_q <= WIDTH'(ZeroWord);
            end else if (early_c) begin
              rem_q <= a_mag_c;
              quo_q <= WIDTH'(ZeroWord);
            end else begin
              rem_q <= '0;
              quo_q <= a_mag_c;
            end
          end
        end
        DIV_BUSY: begin
          if (!stop) begin
            rem_q <= rem_step_c;
            quo_q <= quo_step_c;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DIV_FINI: begin
          if (!ready) begin
            ready  <= 1'b1;
            result <= {rsign_q ? (~rem_q + WIDTH'(1)) : rem_q,
                       qsign_q ? (~quo_q + WIDTH'(1)) : quo_q};
          end else begin
            ready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, scoreboard queue and multi-cycle corner sequences.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic           stop;
  logic [2*W-1:0] result;
  logic           ready;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .start      (start),
    .stop       (stop),
    .result     (result),
    .ready      (ready)
  );

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[10];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  function automatic logic [31:0] mag(input logic sd, input logic [31:0] x);
    return (sd && x[31]) ? (32'd0 - x) : x;
  endfunction

  // Edges from the start edge to the first edge after which ready is seen high.
  function automatic int model_lat(input logic sd, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 2;
`ifdef DIV_EARLY_TERM_EN
    if (mag(sd, x) < mag(sd, y)) return 2;
`endif
    return 33;
  endfunction

  function automatic logic [63:0] model_res(input logic sd, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'd0) return 64'd0;
    if (sd) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sx = x;
      sy = y;
      q  = sx / sy;
      r  = sx % sy;
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  // Present one start for a single edge (E0); returns #1 after E0.
  task automatic issue(input logic sd, input logic [31:0] x, input logic [31:0] y);
    signed_div = sd;
    a          = x;
    b          = y;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic sd, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp_res);
    int   lat;
    exp_t e;
    sb.push_back('{exp_res, model_lat(sd, x, y)});
    issue(sd, x, y);
    wait_ready(40, lat);
    e = sb.pop_front();
    check({name, "_lat"}, 64'(lat), 64'(e.lat));
    check({name, "_res"}, result, e.res);
    @(posedge clk);
    #1;
    check({name, "_pulse"}, {63'd0, ready}, 64'd0);
    check({name, "_hold"}, result, e.res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    vt[0] = '{1'b0, 32'd100,        32'd7,         64'h00000002_0000000E};
    vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD};
    vt[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD};
    vt[3] = '{1'b0, 32'h0000_1234,  32'd0,         64'h00000000_00000000};
    vt[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,        64'h0000000F_0FFFFFFF};
    vt[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000};
    vt[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 64'h80000000_00000000};
    vt[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E};
    vt[8] = '{1'b0, 32'd3,          32'd9,         64'h00000003_00000000};
    vt[9] = '{1'b1, 32'hFFFF_FFFD,  32'd9,         64'hFFFFFFFD_00000000};

    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vt[i].sd, vt[i].a, vt[i].b, vt[i].res);

    // Abort at E10 while busy, then a fresh division must still work.
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_ready(40, lat);
    check("abort_no_ready", 64'(lat), 64'(-1));
    check("abort_result", result, 64'd0);
    run_op("after_abort", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0000000F_0FFFFFFF);

    // start together with stop is ignored.
    signed_div = 1'b0;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    stop       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    wait_ready(40, lat);
    check("start_blocked", 64'(lat), 64'(-1));
    check("start_blocked_hold", result, 64'h0000000F_0FFFFFFF);

    // Synchronous reset at E20 mid-division drops the operation.
    issue(1'b0, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_ready", {63'd0, ready}, 64'd0);
    check("midreset_result", result, 64'd0);
    rst = 1'b0;
    wait_ready(40, lat);
    check("midreset_no_ready", 64'(lat), 64'(-1));
    run_op("after_reset", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);

    // stop raised only once FINI is reached must not suppress the pulse.
    issue(1'b0, 32'd100, 32'd7);
    repeat (32) @(posedge clk);
    #1;
    stop = 1'b1;
    wait_ready(3, lat);
    check("fini_stop_lat", 64'(lat), 64'd1);
    check("fini_stop_res", result, 64'h00000002_0000000E);
    stop = 1'b0;
    @(posedge clk);
    #1;
    check("fini_stop_pulse", {63'd0, ready}, 64'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'd0) rb = 32'd1;
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), rs, ra, rb, model_res(rs, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
